// File: rtl/ccd_pkg.sv
// rtl/ccd_pkg.sv - shared state encoding and widths for the CCD capture slice
package ccd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SOF  = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_STOP_PEND = 2'd3
    } ccd_state_e;

    localparam int CCD_CW     = 11;
    localparam int CCD_FCW    = 32;
    localparam int CCD_DW     = 10;
    localparam int CCD_LINE_W = 1280;

    // Both capturing states pass pixels and count frame ends.
    function automatic logic isCapturing(input logic [1:0] s);
        return (s == ST_CAPTURE) || (s == ST_STOP_PEND);
    endfunction

endpackage

// File: rtl/ccd_xy_counter.sv
// rtl/ccd_xy_counter.sv - pixel column/row counter with line wrap and row saturation
module ccd_xy_counter
    import ccd_pkg::*;
#(
    parameter int LINE_W = CCD_LINE_W,
    parameter int CW     = CCD_CW
)
(
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] xcnt,
    output logic [CW-1:0] ycnt
);

    localparam logic [CW-1:0] X_LAST = CW'(LINE_W - 1);
    localparam logic [CW-1:0] Y_MAX  = '1;

    // Line length comes only from LINE_W; LVAL never resets the column.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            xcnt <= '0;
            ycnt <= '0;
        end else if (clr) begin
            xcnt <= '0;
            ycnt <= '0;
        end else if (inc) begin
            if (xcnt == X_LAST) begin
                xcnt <= '0;
                if (ycnt != Y_MAX)
                    ycnt <= ycnt + 1'b1;
            end else begin
                xcnt <= xcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccd_capture_ctrl.sv
// rtl/ccd_capture_ctrl.sv - CCD capture sequencer; optional frame skipping via CCD_FRAME_SKIP_EN
module ccd_capture_ctrl
    import ccd_pkg::*;
#(
    parameter int LINE_W = CCD_LINE_W,
    parameter int CW     = CCD_CW,
    parameter int FCW    = CCD_FCW
)
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic              iEnd,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic [CCD_DW-1:0] iDATA,
`ifdef CCD_FRAME_SKIP_EN
    input  logic [3:0]        iSkip,
`endif
    output logic [CCD_DW-1:0] oDATA,
    output logic              oDVAL,
    output logic [CW-1:0]     oX_Cont,
    output logic [CW-1:0]     oY_Cont,
    output logic [FCW-1:0]    oFrame_Cont,
    output logic              oBusy
);

    localparam logic [1:0] IDLE      = ST_IDLE;
    localparam logic [1:0] WAIT_SOF  = ST_WAIT_SOF;
    localparam logic [1:0] CAPTURE   = ST_CAPTURE;
    localparam logic [1:0] STOP_PEND = ST_STOP_PEND;

    logic              rFVAL;
    logic              rFVAL_d;
    logic              rLVAL;
    logic [CCD_DW-1:0] rDATA;
    logic [1:0]        state;
    logic [1:0]        stateNext;
    logic              fvRise;
    logic              fvFall;
    logic              active;
    logic              dropFrame;
    logic              nextDrop;
    logic              pix;
    logic              frameDone;
    logic [CW-1:0]     xcnt;
    logic [CW-1:0]     ycnt;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rFVAL   <= 1'b0;
            rFVAL_d <= 1'b0;
            rLVAL   <= 1'b0;
            rDATA   <= '0;
        end else begin
            rFVAL   <= iFVAL;
            rFVAL_d <= rFVAL;
            rLVAL   <= iLVAL;
            rDATA   <= iDATA;
        end
    end

    assign fvRise = rFVAL & ~rFVAL_d;
    assign fvFall = ~rFVAL & rFVAL_d;
    assign active = isCapturing(state);

`ifdef CCD_FRAME_SKIP_EN
    logic [3:0] skipCnt;
    logic       dropping;

    // skipCnt holds how many upcoming frames to drop; dropping marks the frame in flight.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            skipCnt  <= '0;
            dropping <= 1'b0;
        end else if (state == IDLE) begin
            skipCnt  <= '0;
            dropping <= 1'b0;
        end else if (fvRise) begin
            dropping <= (skipCnt != 4'd0);
            if (skipCnt != 4'd0)
                skipCnt <= skipCnt - 4'd1;
        end else if (fvFall && active && !dropping) begin
            skipCnt <= iSkip;
        end
    end

    assign dropFrame = dropping;
    assign nextDrop  = (skipCnt != 4'd0);
`else
    assign dropFrame = 1'b0;
    assign nextDrop  = 1'b0;
`endif

    assign pix       = rFVAL & rLVAL & active & ~dropFrame;
    assign frameDone = fvFall & active & ~dropFrame;

    // Coordinates stay frozen across frames that are going to be dropped.
    ccd_xy_counter #(
        .LINE_W (LINE_W),
        .CW     (CW)
    ) u_xy (
        .iCLK (iCLK),
        .iRST (iRST),
        .clr  (fvRise & ~nextDrop),
        .inc  (pix),
        .xcnt (xcnt),
        .ycnt (ycnt)
    );

    // A simultaneous stop request always beats a start request.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (iStart && !iEnd)
                    stateNext = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (iEnd)
                    stateNext = IDLE;
                else if (fvRise)
                    stateNext = CAPTURE;
            end
            CAPTURE: begin
                if (iEnd)
                    stateNext = STOP_PEND;
            end
            STOP_PEND: begin
                if (iStart && !iEnd)
                    stateNext = CAPTURE;
                else if (fvFall)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state       <= IDLE;
            oBusy       <= 1'b0;
            oDVAL       <= 1'b0;
            oDATA       <= '0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
        end else begin
            state   <= stateNext;
            oBusy   <= (stateNext != IDLE);
            oDVAL   <= pix;
            oDATA   <= pix ? rDATA : '0;
            oX_Cont <= xcnt;
            oY_Cont <= ycnt;
            if (frameDone)
                oFrame_Cont <= oFrame_Cont + 1'b1;
        end
    end

endmodule

// File: tb/tb_ccd_capture_ctrl.sv
// tb/tb_ccd_capture_ctrl.sv - randomized scoreboard bench for ccd_capture_ctrl
module tb_ccd_capture_ctrl;

    localparam int LW  = 8;
    localparam int CW  = 3;
    localparam int FCW = 4;
    localparam int YMAX = (1 << CW) - 1;
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_CAP  = 2;
    localparam int M_STOP = 3;

    logic           iCLK = 1'b0;
    logic           iRST = 1'b0;
    logic           iStart = 1'b0;
    logic           iEnd = 1'b0;
    logic           iFVAL = 1'b0;
    logic           iLVAL = 1'b0;
    logic [9:0]     iDATA = '0;
`ifdef CCD_FRAME_SKIP_EN
    logic [3:0]     iSkip = '0;
`endif
    logic [9:0]     oDATA;
    logic           oDVAL;
    logic [CW-1:0]  oX_Cont;
    logic [CW-1:0]  oY_Cont;
    logic [FCW-1:0] oFrame_Cont;
    logic           oBusy;

    ccd_capture_ctrl #(.LINE_W(LW), .CW(CW), .FCW(FCW)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iStart      (iStart),
        .iEnd        (iEnd),
        .iFVAL       (iFVAL),
        .iLVAL       (iLVAL),
        .iDATA       (iDATA),
`ifdef CCD_FRAME_SKIP_EN
        .iSkip       (iSkip),
`endif
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrame_Cont (oFrame_Cont),
        .oBusy       (oBusy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [9:0]    d;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } pix_t;

    pix_t expQ[$];
    int   nCmp = 0;
    int   nErr = 0;
    bit   monEn = 1'b0;
    int   mState = M_IDLE;
    int   mFrames = 0;
    int   mSkip = 0;
    int   mSkipLeft = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge iCLK) begin
        if (monEn) begin
            if (oDVAL) begin
                if (expQ.size() == 0)
                    check("extra_pixel", oDVAL, 0);
                else
                    check("pixel{data,x,y}", {oDATA, oX_Cont, oY_Cont}, expQ.pop_front());
            end else begin
                check("data_zero_when_invalid", oDATA, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic applyCmd(input bit s, input bit e);
        if (e) begin
            if (mState == M_WAIT) mState = M_IDLE;
            else if (mState == M_CAP) mState = M_STOP;
        end else if (s) begin
            if (mState == M_IDLE) mState = M_WAIT;
            else if (mState == M_STOP) mState = M_CAP;
        end
        if (mState == M_IDLE) mSkipLeft = 0;
    endtask

    task automatic gapCmd(input bit s, input bit e);
        iStart = s;
        iEnd = e;
        tick(1);
        iStart = 1'b0;
        iEnd = 1'b0;
        applyCmd(s, e);
        tick(2);
        check("busy_after_cmd", oBusy, mState != M_IDLE);
    endtask

    // Up to two commands are issued on given pixel indices within the frame.
    task automatic sendFrame(input int lines, input int pA, input bit sA, input bit eA,
                             input int pB, input bit sB, input bit eB);
        logic [9:0] dat[$];
        bit act, drop, cap;
        int idx;
        pix_t p;
        for (int k = 0; k < lines * LW; k++) dat.push_back(10'($urandom));
        act = (mState != M_IDLE);
        if (mState == M_WAIT) mState = M_CAP;
        drop = act && (mSkipLeft > 0);
        if (drop) mSkipLeft--;
        cap = act && !drop;
        if (cap) begin
            for (int k = 0; k < lines * LW; k++) begin
                p.d = dat[k];
                p.x = CW'(k % LW);
                p.y = CW'((k / LW > YMAX) ? YMAX : k / LW);
                expQ.push_back(p);
            end
        end
        iFVAL = 1'b1;
        tick(2);
        idx = 0;
        for (int l = 0; l < lines; l++) begin
            iLVAL = 1'b1;
            for (int x = 0; x < LW; x++) begin
                iDATA = dat[idx];
                if (idx == pA) begin iStart = sA; iEnd = eA; end
                if (idx == pB) begin iStart = sB; iEnd = eB; end
                tick(1);
                if (idx == pA) applyCmd(sA, eA);
                if (idx == pB) applyCmd(sB, eB);
                iStart = 1'b0;
                iEnd = 1'b0;
                idx++;
            end
            iLVAL = 1'b0;
            iDATA = 10'($urandom);
            tick(1 + $urandom_range(0, 2));
        end
        iFVAL = 1'b0;
        if (mState == M_CAP || mState == M_STOP) begin
            if (!drop) begin
                mFrames++;
                mSkipLeft = mSkip;
            end
            if (mState == M_STOP) begin
                mState = M_IDLE;
                mSkipLeft = 0;
            end
        end
        tick(4);
        check("frame_count", oFrame_Cont, mFrames % (1 << FCW));
        check("busy", oBusy, mState != M_IDLE);
        check("pixels_outstanding", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic resetDut();
        monEn = 1'b0;
        iRST = 1'b0;
        tick(2);
        iRST = 1'b1;
        iFVAL = 1'b0;
        iLVAL = 1'b0;
        tick(3);
        expQ.delete();
        mState = M_IDLE;
        mFrames = 0;
        mSkipLeft = 0;
        monEn = 1'b1;
    endtask

    initial begin
        int r;
        tick(3);
        check("rst_oDATA", oDATA, 0);
        check("rst_oDVAL", oDVAL, 0);
        check("rst_oX", oX_Cont, 0);
        check("rst_oY", oY_Cont, 0);
        check("rst_oFrame", oFrame_Cont, 0);
        check("rst_oBusy", oBusy, 0);
        iRST = 1'b1;
        tick(2);
        monEn = 1'b1;

        sendFrame(3, -1, 0, 0, -1, 0, 0);
        sendFrame(2, 4, 0, 1, -1, 0, 0);
        gapCmd(1, 0);
        sendFrame(4, -1, 0, 0, -1, 0, 0);
        sendFrame(4, LW + 3, 0, 1, -1, 0, 0);
        sendFrame(4, -1, 0, 0, -1, 0, 0);
        sendFrame(3, 5, 1, 0, -1, 0, 0);
        sendFrame(2, -1, 0, 0, -1, 0, 0);
        sendFrame(4, 2, 0, 1, 10, 1, 1);
        sendFrame(2, -1, 0, 0, -1, 0, 0);
        gapCmd(1, 0);
        gapCmd(1, 1);
        sendFrame(2, -1, 0, 0, -1, 0, 0);
        gapCmd(1, 0);
        sendFrame(3, 2, 0, 1, 9, 1, 0);
        sendFrame(11, -1, 0, 0, -1, 0, 0);

        // Reset in the middle of a captured frame.
        monEn = 1'b0;
        iFVAL = 1'b1;
        tick(2);
        iLVAL = 1'b1;
        tick(5);
        iRST = 1'b0;
        tick(1);
        check("midrst_oDVAL", oDVAL, 0);
        check("midrst_oBusy", oBusy, 0);
        check("midrst_oFrame", oFrame_Cont, 0);
        check("midrst_oX", oX_Cont, 0);
        iRST = 1'b1;
        iLVAL = 1'b0;
        iFVAL = 1'b0;
        tick(4);
        expQ.delete();
        mState = M_IDLE;
        mFrames = 0;
        mSkipLeft = 0;
        monEn = 1'b1;
        sendFrame(2, -1, 0, 0, -1, 0, 0);
        gapCmd(1, 0);
        sendFrame(2, -1, 0, 0, -1, 0, 0);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 7);
            if (r < 3) gapCmd(1, 0);
            else if (r == 3) gapCmd(0, 1);
            else if (r == 4) gapCmd(1, 1);
            r = $urandom_range(1, 10);
            if ($urandom_range(0, 2) == 0)
                sendFrame(r, $urandom_range(0, r * LW - 1), 1'($urandom), 1'($urandom),
                          $urandom_range(0, r * LW - 1), 1'($urandom), 1'($urandom));
            else
                sendFrame(r, -1, 0, 0, -1, 0, 0);
        end

`ifdef CCD_FRAME_SKIP_EN
        resetDut();
        iSkip = 4'd2;
        mSkip = 2;
        gapCmd(1, 0);
        for (int f = 0; f < 6; f++) sendFrame(2, -1, 0, 0, -1, 0, 0);
        check("skip_total_frames", oFrame_Cont, 2);
        iSkip = 4'd0;
        mSkip = 0;
        sendFrame(2, -1, 0, 0, -1, 0, 0);
        sendFrame(2, -1, 0, 0, -1, 0, 0);
`else
        resetDut();
        gapCmd(1, 0);
        sendFrame(2, -1, 0, 0, -1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
